// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and widths for the 8-bit-instruction core.
// Holds the run-control state encoding used by program_sequencer.
package cpu_pkg;

  localparam int PM_ADDR_W = 8;
  localparam int NIBBLE_W  = 4;

  typedef enum logic [1:0] {
    PS_RUN    = 2'd0,
    PS_HALTED = 2'd1,
    PS_STEP   = 2'd2
  } ps_state_t;

  // Jumps stay inside the current 16-instruction page: keep the page, replace the offset.
  function automatic logic [PM_ADDR_W-1:0] jump_target(
    input logic [PM_ADDR_W-NIBBLE_W-1:0] page,
    input logic [NIBBLE_W-1:0]           offset
  );
    return {page, offset};
  endfunction

endpackage

// File: rtl/program_sequencer.sv
// program_sequencer: program-memory address generation, program counter and
// debug run control (RUN / HALTED / STEP) for the 8-bit-instruction core.
// Optional breakpoint compare is enabled by defining PS_BREAKPOINT_EN; without
// it bp_hit is tied low and bp_valid/bp_addr are ignored.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   PS_RUN     | instruction in ir executes unless a breakpoint matches
//   PS_HALTED  | ir refetched every cycle, nothing executes
//   PS_STEP    | exactly one instruction executes, then back to PS_HALTED
import cpu_pkg::*;

module program_sequencer #(
  parameter bit RESET_HALTED = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 sync_reset,
  input  logic                 jmp,
  input  logic                 jmp_nz,
  input  logic                 dont_jmp,
  input  logic [NIBBLE_W-1:0]  jmp_addr,
  input  logic                 halt_req,
  input  logic                 step_req,
  input  logic                 resume_req,
  input  logic                 bp_valid,
  input  logic [PM_ADDR_W-1:0] bp_addr,
  output logic [PM_ADDR_W-1:0] pm_addr,
  output logic [PM_ADDR_W-1:0] pc,
  output logic                 core_en,
  output logic                 halted,
  output logic                 bp_hit,
  output logic [CNT_W-1:0]     retired,
  output logic [PM_ADDR_W-1:0] from_PS
);

  localparam ps_state_t RESET_STATE = RESET_HALTED ? PS_HALTED : PS_RUN;

  ps_state_t              r_state;
  ps_state_t              w_state_nxt;
  logic [PM_ADDR_W-1:0]   r_pc;
  logic [PM_ADDR_W-1:0]   w_pm_addr;
  logic [CNT_W-1:0]       r_retired;
  logic                   w_advance;
  logic                   w_take_jmp;
  logic                   w_bp_hit;

`ifdef PS_BREAKPOINT_EN
  logic r_skip;
  logic w_skip_set;

  // Leaving HALTED (resume or step) masks the breakpoint for one cycle so the
  // instruction parked at the breakpoint address can execute.
  assign w_skip_set = (r_state == PS_HALTED) && (resume_req || step_req);
  assign w_bp_hit   = !sync_reset && (r_state == PS_RUN) && bp_valid &&
                      (r_pc == bp_addr) && !r_skip;

  // Skip flag: set when leaving HALTED, dropped after one non-halted cycle.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_skip <= 1'b0;
    end else if (w_skip_set) begin
      r_skip <= 1'b1;
    end else if (r_state != PS_HALTED) begin
      r_skip <= 1'b0;
    end
  end
`else
  logic w_bp_unused;

  assign w_bp_unused = ^{bp_valid, bp_addr};
  assign w_bp_hit    = 1'b0;
`endif

  // Run-control next state and the execute enable.
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    case (r_state)
      PS_RUN: begin
        w_advance = !w_bp_hit;
        if (w_bp_hit || halt_req) begin
          w_state_nxt = PS_HALTED;
        end
      end
      PS_HALTED: begin
        if (resume_req) begin
          w_state_nxt = PS_RUN;
        end else if (step_req) begin
          w_state_nxt = PS_STEP;
        end
      end
      PS_STEP: begin
        w_advance   = 1'b1;
        w_state_nxt = PS_HALTED;
      end
      default: begin
        w_state_nxt = RESET_STATE;
      end
    endcase
    if (sync_reset) begin
      w_advance   = 1'b0;
      w_state_nxt = RESET_STATE;
    end
  end

  // Next fetch address: refetch when stalled, otherwise jump or fall through.
  always_comb begin
    w_take_jmp = jmp || (jmp_nz && !dont_jmp);
    w_pm_addr  = r_pc;
    if (sync_reset) begin
      w_pm_addr = '0;
    end else if (w_advance) begin
      if (w_take_jmp) begin
        w_pm_addr = jump_target(r_pc[PM_ADDR_W-1:NIBBLE_W], jmp_addr);
      end else begin
        w_pm_addr = r_pc + PM_ADDR_W'(1);
      end
    end
  end

  // State, program counter and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_state   <= RESET_STATE;
      r_pc      <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pm_addr;
      if (w_advance) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign pm_addr = w_pm_addr;
  assign pc      = r_pc;
  assign from_PS = r_pc;
  assign core_en = w_advance;
  assign halted  = (r_state == PS_HALTED);
  assign bp_hit  = w_bp_hit;
  assign retired = r_retired;

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed scenarios followed by random stimulus, every
// cycle compared against a behavioural model of the sequencer.
module tb_program_sequencer;

  localparam int CNT_W = 16;
  localparam bit RH    = 1'b0;
`ifdef PS_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  logic             clk;
  logic             sync_reset;
  logic             jmp, jmp_nz, dont_jmp;
  logic [3:0]       jmp_addr;
  logic             halt_req, step_req, resume_req;
  logic             bp_valid;
  logic [7:0]       bp_addr;
  logic [7:0]       pm_addr, pc, from_PS;
  logic             core_en, halted, bp_hit;
  logic [CNT_W-1:0] retired;

  program_sequencer #(.RESET_HALTED(RH), .CNT_W(CNT_W)) dut (
    .clk(clk), .sync_reset(sync_reset),
    .jmp(jmp), .jmp_nz(jmp_nz), .dont_jmp(dont_jmp), .jmp_addr(jmp_addr),
    .halt_req(halt_req), .step_req(step_req), .resume_req(resume_req),
    .bp_valid(bp_valid), .bp_addr(bp_addr),
    .pm_addr(pm_addr), .pc(pc), .core_en(core_en), .halted(halted),
    .bp_hit(bp_hit), .retired(retired), .from_PS(from_PS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: program counter, counter and debug mode as plain variables.
  int m_pc, m_ret;
  bit m_halted, m_stepping, m_skip;
  logic [7:0] s_pm;
  logic       s_en, s_hit;

  task automatic model_reset();
    m_pc = 0; m_ret = 0; m_skip = 0; m_halted = RH; m_stepping = 0;
  endtask

  // Called at posedge+1 with inputs set: checks mid-cycle, then advances one clock.
  task automatic tick();
    int e_pm;
    bit e_hit, e_en;
    #4;
    if (sync_reset) begin
      e_pm = 0; e_hit = 0; e_en = 0;
    end else begin
      e_hit = BP_EN && !m_halted && !m_stepping && bp_valid &&
              (m_pc == int'(bp_addr)) && !m_skip;
      e_en  = m_stepping || (!m_halted && !e_hit);
      if (!e_en) e_pm = m_pc;
      else if (jmp || (jmp_nz && !dont_jmp)) e_pm = (m_pc & 'hF0) | int'(jmp_addr);
      else e_pm = (m_pc + 1) % 256;
    end
    s_pm = pm_addr; s_en = core_en; s_hit = bp_hit;
    chk("pm_addr", pm_addr, e_pm);
    chk("core_en", core_en, e_en);
    chk("bp_hit", bp_hit, e_hit);
    chk("pc", pc, m_pc);
    chk("from_PS", from_PS, m_pc);
    chk("halted", halted, m_halted);
    chk("retired", retired, m_ret);
    @(posedge clk);
    if (sync_reset) begin
      model_reset();
    end else begin
      if (e_en) m_ret = (m_ret + 1) % (1 << CNT_W);
      m_pc = e_pm;
      if (m_stepping) begin
        m_stepping = 0; m_halted = 1; m_skip = 0;
      end else if (m_halted) begin
        if (resume_req) begin
          m_halted = 0; m_skip = 1;
        end else if (step_req) begin
          m_halted = 0; m_stepping = 1; m_skip = 1;
        end
      end else begin
        m_skip = 0;
        if (e_hit || halt_req) m_halted = 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    jmp = 0; jmp_nz = 0; dont_jmp = 0; jmp_addr = 4'h0;
    halt_req = 0; step_req = 0; resume_req = 0;
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 300 && m_pc != target; k++) tick();
    chk("run_to", pc, target);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved_ret;
    int cnt;
    idle();
    sync_reset = 1; bp_valid = 0; bp_addr = 8'h00;
    @(posedge clk); #1;
    model_reset();
    tick();
    chk("rst_pc", pc, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, RH);
    chk("rst_pm", s_pm, 0);
    sync_reset = 0;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("inc_pm", s_pm, i + 1);
    end
    chk("retired5", retired, 5);

    run_to(8'hFF);
    tick();
    chk("wrap_pm", s_pm, 8'h00);

    run_to(8'h37);
    jmp = 1; jmp_addr = 4'hA;
    tick();
    chk("jmp_pm", s_pm, 8'h3A);
    jmp = 0; jmp_nz = 1; dont_jmp = 1; jmp_addr = 4'h2;
    tick();
    chk("jnz_blocked_pm", s_pm, 8'h3B);
    dont_jmp = 0; jmp_addr = 4'h5;
    tick();
    chk("jnz_taken_pm", s_pm, 8'h35);
    idle();

    run_to(8'h10);
    halt_req = 1;
    tick();
    halt_req = 0;
    chk("halt_exec_en", s_en, 1);
    chk("halt_state", halted, 1);
    chk("halt_pc", pc, 8'h11);
    saved_ret = m_ret;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_pm", s_pm, 8'h11);
      chk("hold_en", s_en, 0);
    end
    chk("hold_retired", retired, saved_ret);

    step_req = 1;
    tick();
    step_req = 0;
    tick();
    chk("step_en", s_en, 1);
    chk("step_pm", s_pm, 8'h12);
    chk("step_halted", halted, 1);
    chk("step_pc", pc, 8'h12);
    chk("step_retired", retired, saved_ret + 1);

    step_req = 1; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      cnt += int'(s_en);
    end
    step_req = 0;
    chk("step_held_count", cnt, 4);
    chk("step_held_pc", pc, 8'h16);

    resume_req = 1; step_req = 1;
    tick();
    idle();
    chk("resume_beats_step", halted, 0);
    tick();
    chk("resume_run_en", s_en, 1);

    bp_valid = 1; bp_addr = 8'h20;
    run_to(8'h20);
    tick();
`ifdef PS_BREAKPOINT_EN
    chk("bp_hit_cycle", s_hit, 1);
    chk("bp_en_cycle", s_en, 0);
    chk("bp_halted", halted, 1);
    chk("bp_pc", pc, 8'h20);
    resume_req = 1;
    tick();
    resume_req = 0;
    tick();
    chk("bp_resume_nohit", s_hit, 0);
    chk("bp_resume_pm", s_pm, 8'h21);
`else
    chk("bp_off_en", s_en, 1);
    chk("bp_off_pm", s_pm, 8'h21);
`endif
    bp_valid = 0;

    halt_req = 1;
    tick();
    halt_req = 0; step_req = 1;
    tick();
    step_req = 0; sync_reset = 1;
    tick();
    sync_reset = 0;
    chk("rst_step_pc", pc, 0);
    chk("rst_step_halted", halted, RH);
    chk("rst_step_retired", retired, 0);

    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) bp_addr = 8'($urandom_range(0, 255));
      jmp        = ($urandom_range(0, 3) == 0);
      jmp_nz     = ($urandom_range(0, 3) == 0);
      dont_jmp   = 1'($urandom_range(0, 1));
      jmp_addr   = 4'($urandom_range(0, 15));
      halt_req   = ($urandom_range(0, 15) == 0);
      step_req   = ($urandom_range(0, 7) == 0);
      resume_req = ($urandom_range(0, 7) == 0);
      bp_valid   = ($urandom_range(0, 3) != 0);
      sync_reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    idle();
    sync_reset = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
